// File: rtl/sync_barrier_ctrl_if.sv
// Barrier controller bus: per-core ready/halt/join/spawn requests
// and the resulting go/enable/release/timeout outputs.
interface sync_barrier_ctrl_if #(
    parameter int NCORES  = 16,
    parameter int NGROUPS = 16,
    parameter int CW      = $clog2(NCORES),
    parameter int GW      = $clog2(NGROUPS)
);
    logic [NCORES-1:0]    core_ready;
    logic [NCORES-1:0]    core_halted;
    logic [NCORES-1:0]    sync_req;
    logic [NCORES*GW-1:0] sync_group;
    logic [NCORES-1:0]    spawn_req;
    logic [NCORES*CW-1:0] spawn_id;
    logic [NCORES-1:0]    core_go;
    logic [NCORES-1:0]    core_enable;
    logic [NGROUPS-1:0]   group_release;
    logic [NGROUPS-1:0]   timeout_err;

    modport master (
        output core_ready, core_halted, sync_req, sync_group,
        output spawn_req, spawn_id,
        input  core_go, core_enable, group_release, timeout_err
    );

    modport slave (
        input  core_ready, core_halted, sync_req, sync_group,
        input  spawn_req, spawn_id,
        output core_go, core_enable, group_release, timeout_err
    );
endinterface

// File: rtl/sync_barrier_ctrl.sv
// Sync-group barrier controller: group membership, spawn inheritance,
// per-group barrier FSM with release pulses and sticky wait timeout.
module sync_barrier_ctrl #(
    parameter int NCORES    = 16,
    parameter int NGROUPS   = 16,
    parameter int BOOT_CORE = 0,
    parameter int TIMEOUT   = 1024,
    parameter int CW        = $clog2(NCORES),
    parameter int GW        = $clog2(NGROUPS)
) (
    input logic                clk,
    input logic                rst,
    sync_barrier_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REL, S_HOLD} state_e;

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [NCORES-1:0] BOOT_MASK = NCORES'(1) << BOOT_CORE;

    logic [GW-1:0]      member_q [NCORES];
    logic [GW-1:0]      member_d [NCORES];
    logic [NCORES-1:0]  enable_q, enable_d;
    state_e             state_q  [NGROUPS];
    state_e             state_d  [NGROUPS];
    logic [TW-1:0]      cnt_q    [NGROUPS];
    logic [TW-1:0]      cnt_d    [NGROUPS];
    logic [NCORES-1:0]  go_q, go_d;
    logic [NGROUPS-1:0] rel_q, rel_d;
    logic [NGROUPS-1:0] terr_q, terr_d;

    logic [NCORES-1:0]  active;
    logic [NCORES-1:0]  act      [NGROUPS];
    logic [NGROUPS-1:0] any_rdy, rdy_all, mchg;
    logic [CW-1:0]      tgt;

    assign active = enable_q & ~bus.core_halted;

    // Membership and enable update: halt, join, then spawn (lowest parent wins)
    always_comb begin
        enable_d = enable_q;
        tgt      = '0;
        for (int c = 0; c < NCORES; c++) begin
            member_d[c] = member_q[c];
            if (bus.core_halted[c])
                enable_d[c] = 1'b0;
            if (bus.sync_req[c] &&
                (int'(bus.sync_group[c*GW +: GW]) < NGROUPS))
                member_d[c] = bus.sync_group[c*GW +: GW];
        end
        for (int p = NCORES - 1; p >= 0; p--) begin
            tgt = bus.spawn_id[p*CW +: CW];
            if (bus.spawn_req[p] && (int'(tgt) != p) &&
                (int'(tgt) < NCORES)) begin
                enable_d[tgt] = 1'b1;
                member_d[tgt] = member_q[p];
            end
        end
    end

    // Per-group active set, ready summary and membership-change detect
    always_comb begin
        for (int g = 0; g < NGROUPS; g++) begin
            act[g]  = '0;
            mchg[g] = 1'b0;
            for (int c = 0; c < NCORES; c++) begin
                act[g][c] = active[c] && (member_q[c] == GW'(g));
                mchg[g]   = mchg[g] |
                    ((enable_q[c] && (member_q[c] == GW'(g))) ^
                     (enable_d[c] && (member_d[c] == GW'(g))));
            end
            any_rdy[g] = |(act[g] & bus.core_ready);
            rdy_all[g] = (act[g] != '0) &&
                         ((act[g] & ~bus.core_ready) == '0);
        end
    end

    // Barrier next-state, wait counter and sticky timeout (groups >= 1)
    always_comb begin
        for (int g = 0; g < NGROUPS; g++) begin
            state_d[g] = state_q[g];
            cnt_d[g]   = '0;
            terr_d[g]  = terr_q[g];
            if (g != 0) begin
                unique case (state_q[g])
                    S_IDLE: if (any_rdy[g]) state_d[g] = S_WAIT;
                    S_WAIT: begin
                        if (rdy_all[g])
                            state_d[g] = S_REL;
                        else if (!any_rdy[g])
                            state_d[g] = S_IDLE;
                    end
                    S_REL:   state_d[g] = S_HOLD;
                    S_HOLD:  state_d[g] = S_IDLE;
                    default: state_d[g] = S_IDLE;
                endcase
                if ((state_q[g] == S_WAIT) && (state_d[g] == S_WAIT) &&
                    !mchg[g])
                    cnt_d[g] = (cnt_q[g] == TMAX) ? cnt_q[g]
                                                  : cnt_q[g] + TW'(1);
                if ((TIMEOUT > 0) && (state_d[g] == S_WAIT) &&
                    (cnt_d[g] == TMAX))
                    terr_d[g] = 1'b1;
            end
        end
    end

    // Go permissions and release pulses, registered next edge
    always_comb begin
        go_d  = '0;
        rel_d = '0;
        for (int c = 0; c < NCORES; c++) begin
            if (active[c]) begin
                if (member_q[c] == '0)
                    go_d[c] = 1'b1;
                else if ((state_q[member_q[c]] == S_WAIT) &&
                         rdy_all[member_q[c]])
                    go_d[c] = 1'b1;
            end
        end
        for (int g = 1; g < NGROUPS; g++)
            rel_d[g] = (state_q[g] == S_WAIT) && rdy_all[g];
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= BOOT_MASK;
            go_q     <= '0;
            rel_q    <= '0;
            terr_q   <= '0;
            for (int c = 0; c < NCORES; c++)
                member_q[c] <= '0;
            for (int g = 0; g < NGROUPS; g++) begin
                state_q[g] <= S_IDLE;
                cnt_q[g]   <= '0;
            end
        end else begin
            enable_q <= enable_d;
            go_q     <= go_d;
            rel_q    <= rel_d;
            terr_q   <= terr_d;
            for (int c = 0; c < NCORES; c++)
                member_q[c] <= member_d[c];
            for (int g = 0; g < NGROUPS; g++) begin
                state_q[g] <= state_d[g];
                cnt_q[g]   <= cnt_d[g];
            end
        end
    end

    assign bus.core_go       = go_q;
    assign bus.core_enable   = enable_q;
    assign bus.group_release = rel_q;
    assign bus.timeout_err   = terr_q;
endmodule

// File: tb/tb_sync_barrier_ctrl.sv
// Directed bench for sync_barrier_ctrl: reset, spawn, barrier release,
// spawn priority, timeout with halt-completed barrier, async reset.
module tb_sync_barrier_ctrl;
    localparam int NC  = 16;
    localparam int NG  = 16;
    localparam int CWB = 4;
    localparam int GWB = 4;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    sync_barrier_ctrl_if #(.NCORES(NC), .NGROUPS(NG)) bus ();

    sync_barrier_ctrl #(
        .NCORES(NC), .NGROUPS(NG), .BOOT_CORE(0), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic join_grp(input int c, input int g);
        bus.sync_req[c] = 1'b1;
        bus.sync_group[c*GWB +: GWB] = GWB'(g);
    endtask

    task automatic spawn(input int p, input int t);
        bus.spawn_req[p] = 1'b1;
        bus.spawn_id[p*CWB +: CWB] = CWB'(t);
    endtask

    task automatic idle_in();
        bus.sync_req  = '0;
        bus.spawn_req = '0;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (bus.core_enable !== 16'h0001) begin
            tests_failed++;
            $display("FAIL rst_enable: got %h want %h", bus.core_enable, 16'h0001);
        end
        tests_run++;
        if (bus.core_go !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_go: got %h want %h", bus.core_go, 16'h0000);
        end
        tests_run++;
        if (bus.group_release !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_rel: got %h want %h", bus.group_release, 16'h0000);
        end
        tests_run++;
        if (bus.timeout_err !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_terr: got %h want %h", bus.timeout_err, 16'h0000);
        end
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (bus.core_go !== 16'h0001) begin
            tests_failed++;
            $display("FAIL boot_go: got %h want %h", bus.core_go, 16'h0001);
        end
    endtask

    task automatic test_spawn();
        spawn(0, 3);
        tick();
        idle_in();
        tests_run++;
        if (bus.core_enable !== 16'h0009) begin
            tests_failed++;
            $display("FAIL spawn_en: got %h want %h", bus.core_enable, 16'h0009);
        end
        tick();
        tests_run++;
        if (bus.core_go !== 16'h0009) begin
            tests_failed++;
            $display("FAIL spawn_go: got %h want %h", bus.core_go, 16'h0009);
        end
        spawn(0, 1);
        tick();
        spawn(0, 2);
        tick();
        idle_in();
        tick();
        tests_run++;
        if (bus.core_go !== 16'h000F) begin
            tests_failed++;
            $display("FAIL spawn12_go: got %h want %h", bus.core_go, 16'h000F);
        end
    endtask

    task automatic test_barrier();
        join_grp(1, 5);
        join_grp(2, 5);
        tick();
        idle_in();
        tick();
        tests_run++;
        if (bus.core_go !== 16'h0009) begin
            tests_failed++;
            $display("FAIL join_go: got %h want %h", bus.core_go, 16'h0009);
        end
        bus.core_ready[1] = 1'b1;
        tick();
        tests_run++;
        if (bus.core_go !== 16'h0009) begin
            tests_failed++;
            $display("FAIL half_go: got %h want %h", bus.core_go, 16'h0009);
        end
        repeat (3) tick();
        bus.core_ready[2] = 1'b1;
        tick();
        tests_run++;
        if (bus.core_go !== 16'h000F) begin
            tests_failed++;
            $display("FAIL rel_go: got %h want %h", bus.core_go, 16'h000F);
        end
        tests_run++;
        if (bus.group_release !== 16'h0020) begin
            tests_failed++;
            $display("FAIL rel_pulse: got %h want %h", bus.group_release, 16'h0020);
        end
        tick();
        tests_run++;
        if (bus.core_go !== 16'h0009) begin
            tests_failed++;
            $display("FAIL hold_go: got %h want %h", bus.core_go, 16'h0009);
        end
        tests_run++;
        if (bus.group_release !== 16'h0000) begin
            tests_failed++;
            $display("FAIL hold_rel: got %h want %h", bus.group_release, 16'h0000);
        end
        bus.core_ready[1] = 1'b0;
        bus.core_ready[2] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_spawn_priority();
        join_grp(1, 2);
        join_grp(2, 7);
        tick();
        idle_in();
        spawn(1, 4);
        spawn(2, 4);
        tick();
        idle_in();
        tests_run++;
        if (bus.core_enable !== 16'h001F) begin
            tests_failed++;
            $display("FAIL prio_en: got %h want %h", bus.core_enable, 16'h001F);
        end
        join_grp(1, 9);
        join_grp(2, 10);
        tick();
        idle_in();
        tick();
        bus.core_ready[4] = 1'b1;
        tick();
        tests_run++;
        if (bus.group_release !== 16'h0000) begin
            tests_failed++;
            $display("FAIL prio_early: got %h want %h", bus.group_release, 16'h0000);
        end
        tick();
        tests_run++;
        if (bus.group_release !== 16'h0004) begin
            tests_failed++;
            $display("FAIL prio_grp: got %h want %h", bus.group_release, 16'h0004);
        end
        tests_run++;
        if (bus.core_go !== 16'h0019) begin
            tests_failed++;
            $display("FAIL prio_go: got %h want %h", bus.core_go, 16'h0019);
        end
        bus.core_ready[4] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        join_grp(1, 3);
        join_grp(2, 3);
        tick();
        idle_in();
        tick();
        bus.core_ready[1] = 1'b1;
        repeat (8) tick();
        tests_run++;
        if (bus.timeout_err !== 16'h0000) begin
            tests_failed++;
            $display("FAIL to_early: got %h want %h", bus.timeout_err, 16'h0000);
        end
        tests_run++;
        if (bus.core_go !== 16'h0009) begin
            tests_failed++;
            $display("FAIL to_wait_go: got %h want %h", bus.core_go, 16'h0009);
        end
        tick();
        tests_run++;
        if (bus.timeout_err !== 16'h0008) begin
            tests_failed++;
            $display("FAIL to_set: got %h want %h", bus.timeout_err, 16'h0008);
        end
        bus.core_halted[2] = 1'b1;
        tick();
        tests_run++;
        if (bus.core_go !== 16'h000B) begin
            tests_failed++;
            $display("FAIL halt_go: got %h want %h", bus.core_go, 16'h000B);
        end
        tests_run++;
        if (bus.group_release !== 16'h0008) begin
            tests_failed++;
            $display("FAIL halt_rel: got %h want %h", bus.group_release, 16'h0008);
        end
        bus.core_ready[1] = 1'b0;
        tick();
        tests_run++;
        if (bus.core_enable !== 16'h001B) begin
            tests_failed++;
            $display("FAIL halt_en: got %h want %h", bus.core_enable, 16'h001B);
        end
        tests_run++;
        if (bus.timeout_err !== 16'h0008) begin
            tests_failed++;
            $display("FAIL to_sticky: got %h want %h", bus.timeout_err, 16'h0008);
        end
        tests_run++;
        if (bus.core_go !== 16'h0009) begin
            tests_failed++;
            $display("FAIL post_go: got %h want %h", bus.core_go, 16'h0009);
        end
    endtask

    task automatic test_reset_mid();
        join_grp(1, 6);
        join_grp(4, 6);
        tick();
        idle_in();
        tick();
        bus.core_ready[1] = 1'b1;
        tick();
        bus.core_ready[4] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.core_enable !== 16'h0001) begin
            tests_failed++;
            $display("FAIL arst_en: got %h want %h", bus.core_enable, 16'h0001);
        end
        tests_run++;
        if (bus.core_go !== 16'h0000) begin
            tests_failed++;
            $display("FAIL arst_go: got %h want %h", bus.core_go, 16'h0000);
        end
        tests_run++;
        if (bus.timeout_err !== 16'h0000) begin
            tests_failed++;
            $display("FAIL arst_terr: got %h want %h", bus.timeout_err, 16'h0000);
        end
        tick();
        rst = 1'b0;
        bus.core_halted = '0;
        tick();
        tests_run++;
        if (bus.core_go !== 16'h0001) begin
            tests_failed++;
            $display("FAIL post_rst_go: got %h want %h", bus.core_go, 16'h0001);
        end
        tests_run++;
        if (bus.group_release !== 16'h0000) begin
            tests_failed++;
            $display("FAIL post_rst_rel: got %h want %h", bus.group_release, 16'h0000);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst             = 1'b1;
        bus.core_ready  = '0;
        bus.core_halted = '0;
        bus.sync_req    = '0;
        bus.sync_group  = '0;
        bus.spawn_req   = '0;
        bus.spawn_id    = '0;
        test_reset();
        test_spawn();
        test_barrier();
        test_spawn_priority();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
